fixed_point_divider: RTL and testbench

FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

---
 rtl/fixed_point_divider.sv | 214 +++++++++++++++++++++
 tb/tb_fixed_point_divider.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// Signed restoring divider with fixed-point dividend scaling, quotient saturation and a valid/ready handshake.
// Optional feature macro: DIVIDER_REMAINDER_EN adds the signed remainder_out port and its sign fixup.

module fixed_point_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 0,
  parameter int OUT_SIZE  = 20
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [WIDTH-1:0]    dividend_in,
  input  logic [WIDTH-1:0]    divisor_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [OUT_SIZE-1:0] quotient_out,
`ifdef DIVIDER_REMAINDER_EN
  output logic [WIDTH-1:0]    remainder_out,
`endif
  output logic                valid_out,
  input  logic                ready_in,
  output logic                error_out,
  output logic                overflow_out,
  output logic                busy_out
);

  localparam int N    = WIDTH + FRAC_BITS;
  localparam int CNTW = $clog2(N + 1);
  localparam int CW   = ((N > OUT_SIZE) ? N : OUT_SIZE) + 1;

  localparam logic [CW-1:0] POS_LIMIT = {{(CW-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam logic [CW-1:0] NEG_LIMIT = POS_LIMIT + 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDING,
    FIXUP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                ready_q, ready_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]        shift_q, shift_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH:0]      dsr_q, dsr_d;
  logic                negQ_q, negQ_d;
  logic                zero_q, zero_d;
  logic [OUT_SIZE-1:0] quot_q, quot_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
`ifdef DIVIDER_REMAINDER_EN
  logic                negR_q, negR_d;
  logic [WIDTH-1:0]    remOut_q, remOut_d;
`endif

  logic [WIDTH-1:0]    dvdAbs, dsrAbs;
  logic [WIDTH:0]      remShift;
  logic [WIDTH-1:0]    remDiff;
  logic                fits;
  logic [CW-1:0]       magExt;
  logic [OUT_SIZE-1:0] satQuot;
  logic                satOvf;

  // Operand magnitudes; negating the most negative value wraps to the correct unsigned magnitude.
  always_comb begin
    dvdAbs = dividend_in[WIDTH-1] ? (~dividend_in + 1'b1) : dividend_in;
    dsrAbs = divisor_in[WIDTH-1]  ? (~divisor_in  + 1'b1) : divisor_in;
  end

  // One restoring step: the partial remainder stays below the divisor, so WIDTH bits hold it.
  always_comb begin
    remShift = {rem_q, shift_q[N-1]};
    fits     = (remShift >= dsr_q);
    remDiff  = remShift[WIDTH-1:0] - dsr_q[WIDTH-1:0];
  end

  always_comb begin
    magExt  = {{(CW-N){1'b0}}, shift_q};
    satQuot = '0;
    satOvf  = 1'b0;
    if (negQ_q) begin
      if (magExt > NEG_LIMIT) begin
        satQuot = {1'b1, {(OUT_SIZE-1){1'b0}}};
        satOvf  = 1'b1;
      end else begin
        satQuot = ~magExt[OUT_SIZE-1:0] + 1'b1;
      end
    end else begin
      if (magExt > POS_LIMIT) begin
        satQuot = {1'b0, {(OUT_SIZE-1){1'b1}}};
        satOvf  = 1'b1;
      end else begin
        satQuot = magExt[OUT_SIZE-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    negQ_d   = negQ_q;
    zero_d   = zero_q;
    quot_d   = quot_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
`ifdef DIVIDER_REMAINDER_EN
    negR_d   = negR_q;
    remOut_d = remOut_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          cnt_d   = '0;
          shift_d = N'(dvdAbs) << FRAC_BITS;
          rem_d   = '0;
          dsr_d   = {1'b0, dsrAbs};
          negQ_d  = dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
          zero_d  = (divisor_in == '0);
`ifdef DIVIDER_REMAINDER_EN
          negR_d  = dividend_in[WIDTH-1];
`endif
          state_d = DIVIDING;
        end
      end
      DIVIDING: begin
        // A zero divisor skips the iterations and the sign fixup entirely.
        if (zero_q) begin
          quot_d   = '0;
          err_d    = 1'b1;
          ovf_d    = 1'b0;
`ifdef DIVIDER_REMAINDER_EN
          remOut_d = '0;
`endif
          state_d  = DONE;
        end else begin
          shift_d = {shift_q[N-2:0], fits};
          rem_d   = fits ? remDiff : remShift[WIDTH-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNTW'(N - 1)) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        quot_d   = satQuot;
        ovf_d    = satOvf;
        err_d    = 1'b0;
`ifdef DIVIDER_REMAINDER_EN
        remOut_d = negR_q ? (~rem_q + 1'b1) : rem_q;
`endif
        state_d  = DONE;
      end
      DONE: begin
        if (ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // ready is registered so it stays low during reset and has no path from ready_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      negQ_q   <= 1'b0;
      zero_q   <= 1'b0;
      quot_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
      negR_q   <= 1'b0;
      remOut_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      negQ_q   <= negQ_d;
      zero_q   <= zero_d;
      quot_q   <= quot_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
`ifdef DIVIDER_REMAINDER_EN
      negR_q   <= negR_d;
      remOut_q <= remOut_d;
`endif
    end
  end

  assign ready_out     = ready_q;
  assign busy_out      = (state_q != IDLE);
  assign valid_out     = (state_q == DONE);
  assign quotient_out  = quot_q;
  assign error_out     = err_q;
  assign overflow_out  = ovf_q;
`ifdef DIVIDER_REMAINDER_EN
  assign remainder_out = remOut_q;
`endif

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: one instance with FRAC_BITS=0 and one with FRAC_BITS=8.
module tb_fixed_point_divider;

  localparam int W  = 32;
  localparam int OS = 20;
`ifdef DIVIDER_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic [W-1:0]  dvd0, dsr0, dvd8, dsr8;
  logic          vin0, vin8, rin0, rin8;
  logic          rdy0, rdy8, vout0, vout8, err0, err8, ovf0, ovf8, busy0, busy8;
  logic [OS-1:0] quot0, quot8;
`ifdef DIVIDER_REMAINDER_EN
  logic [W-1:0]  rem0, rem8;
`endif

  fixed_point_divider #(.WIDTH(W), .FRAC_BITS(0), .OUT_SIZE(OS)) dut0 (
    .clk_in(clk), .rst_n_in(rstN), .dividend_in(dvd0), .divisor_in(dsr0),
    .valid_in(vin0), .ready_out(rdy0), .quotient_out(quot0),
`ifdef DIVIDER_REMAINDER_EN
    .remainder_out(rem0),
`endif
    .valid_out(vout0), .ready_in(rin0), .error_out(err0), .overflow_out(ovf0), .busy_out(busy0)
  );

  fixed_point_divider #(.WIDTH(W), .FRAC_BITS(8), .OUT_SIZE(OS)) dut8 (
    .clk_in(clk), .rst_n_in(rstN), .dividend_in(dvd8), .divisor_in(dsr8),
    .valid_in(vin8), .ready_out(rdy8), .quotient_out(quot8),
`ifdef DIVIDER_REMAINDER_EN
    .remainder_out(rem8),
`endif
    .valid_out(vout8), .ready_in(rin8), .error_out(err8), .overflow_out(ovf8), .busy_out(busy8)
  );

  typedef struct {
    string         name;
    logic [OS-1:0] q;
    logic [W-1:0]  r;
    logic          err;
    logic          ovf;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  int            obsLat;
  logic [OS-1:0] obsQ;
  logic [W-1:0]  obsR;
  logic          obsErr, obsOvf;

  function automatic exp_t mk(string n, int q, int r, bit e, bit o, int lat);
    exp_t x;
    x.name = n;
    x.q    = q[OS-1:0];
    x.r    = r;
    x.err  = e;
    x.ovf  = o;
    x.lat  = lat;
    return x;
  endfunction

  // Reference arithmetic in 64-bit signed integers: truncating divide, remainder follows dividend.
  function automatic exp_t model(string n, logic [W-1:0] a, logic [W-1:0] b, int frac);
    exp_t   x;
    longint sa, sd, scaled, q, r;
    sa     = longint'($signed(a));
    sd     = longint'($signed(b));
    scaled = sa * (longint'(1) << frac);
    x.name = n;
    x.lat  = W + frac + 2;
    if (sd == 0) begin
      x.q = '0; x.r = '0; x.err = 1'b1; x.ovf = 1'b0; x.lat = 2;
      return x;
    end
    q     = scaled / sd;
    r     = scaled % sd;
    x.err = 1'b0;
    x.ovf = 1'b0;
    if (q > 524287) begin q = 524287; x.ovf = 1'b1; end
    if (q < -524288) begin q = -524288; x.ovf = 1'b1; end
    x.q = q[OS-1:0];
    x.r = r[W-1:0];
    return x;
  endfunction

  task automatic drive(input bit which, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(which ? rdy8 : rdy0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (which) begin dvd8 = a; dsr8 = b; vin8 = 1'b1; end
    else       begin dvd0 = a; dsr0 = b; vin0 = 1'b1; end
    @(posedge clk);
    #1;
    vin0 = 1'b0;
    vin8 = 1'b0;
  endtask

  task automatic collect(input bit which);
    obsLat = 0;
    while (obsLat < 200) begin
      @(negedge clk);
      obsLat++;
      if (which ? vout8 : vout0) break;
    end
    if (!(which ? vout8 : vout0)) obsLat = -1;
    obsQ   = which ? quot8 : quot0;
    obsErr = which ? err8 : err0;
    obsOvf = which ? ovf8 : ovf0;
`ifdef DIVIDER_REMAINDER_EN
    obsR   = which ? rem8 : rem0;
`else
    obsR   = '0;
`endif
  endtask

  task automatic accept(input bit which);
    if (which) rin8 = 1'b1; else rin0 = 1'b1;
    @(posedge clk);
    #1;
    rin0 = 1'b0;
    rin8 = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    vin0 = 1'b0; vin8 = 1'b0; rin0 = 1'b0; rin8 = 1'b0;
    dvd0 = '0; dsr0 = '0; dvd8 = '0; dsr8 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || rdy8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %b/%b expected 0/0", rdy0, rdy8);
    end
    checks++;
    if (busy0 !== 1'b0 || vout0 !== 1'b0 || err0 !== 1'b0 || ovf0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got busy=%b valid=%b err=%b ovf=%b expected all 0", busy0, vout0, err0, ovf0);
    end
    checks++;
    if (quot0 !== '0 || quot8 !== '0 || busy8 !== 1'b0 || vout8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got q0=%0d q8=%0d busy8=%b valid8=%b expected 0", quot0, quot8, busy8, vout8);
    end
`ifdef DIVIDER_REMAINDER_EN
    checks++;
    if (rem0 !== '0 || rem8 !== '0) begin
      fails++;
      $display("[TB] FAIL reset_remainder: got %0d/%0d expected 0", rem0, rem8);
    end
`endif
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy0 !== 1'b1 || rdy8 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL release_ready: got ready=%b/%b busy=%b expected 1/1 busy 0", rdy0, rdy8, busy0);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] va[9];
    logic [W-1:0] vb[9];
    exp_t         ve[9];
    exp_t         e;
    va[0] = 32'd100;      vb[0] = 32'd7;        ve[0] = mk("100/7", 14, 2, 0, 0, 34);
    va[1] = -32'sd100;    vb[1] = 32'd7;        ve[1] = mk("-100/7", -14, -2, 0, 0, 34);
    va[2] = 32'd100;      vb[2] = -32'sd7;      ve[2] = mk("100/-7", -14, 2, 0, 0, 34);
    va[3] = -32'sd100;    vb[3] = -32'sd7;      ve[3] = mk("-100/-7", 14, -2, 0, 0, 34);
    va[4] = 32'h80000000; vb[4] = 32'hFFFFFFFF; ve[4] = mk("min/-1", 524287, 0, 0, 1, 34);
    va[5] = 32'h80000000; vb[5] = 32'd1;        ve[5] = mk("min/1", -524288, 0, 0, 1, 34);
    va[6] = 32'd524287;   vb[6] = 32'd1;        ve[6] = mk("maxpos/1", 524287, 0, 0, 0, 34);
    va[7] = 32'd524288;   vb[7] = 32'd1;        ve[7] = mk("maxpos+1/1", 524287, 0, 0, 1, 34);
    va[8] = -32'sd524288; vb[8] = 32'd1;        ve[8] = mk("minneg/1", -524288, 0, 0, 0, 34);
    for (int i = 0; i < 9; i++) begin
      sb.push_back(ve[i]);
      drive(1'b0, va[i], vb[i]);
      collect(1'b0);
      e = sb.pop_front();
      checks++;
      if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
        fails++;
        $display("[TB] FAIL %s: got lat=%0d q=%0d r=%0d err=%b ovf=%b, expected lat=%0d q=%0d r=%0d err=%b ovf=%b",
                 e.name, obsLat, $signed(obsQ), $signed(obsR), obsErr, obsOvf, e.lat, $signed(e.q), $signed(e.r), e.err, e.ovf);
      end
      accept(1'b0);
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    sb.push_back(mk("5/0", 0, 0, 1, 0, 2));
    sb.push_back(mk("-9/0", 0, 0, 1, 0, 2));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0) ? 32'd5 : -32'sd9, 32'd0);
      collect(1'b0);
      e = sb.pop_front();
      checks++;
      if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
        fails++;
        $display("[TB] FAIL %s: got lat=%0d q=%0d r=%0d err=%b ovf=%b, expected lat=%0d q=%0d r=%0d err=%b ovf=%b",
                 e.name, obsLat, $signed(obsQ), $signed(obsR), obsErr, obsOvf, e.lat, $signed(e.q), $signed(e.r), e.err, e.ovf);
      end
      accept(1'b0);
    end
  endtask

  task automatic test_frac();
    exp_t e;
    sb.push_back(mk("frac 1/2", 128, 0, 0, 0, 42));
    sb.push_back(mk("frac -3/4", -192, 0, 0, 0, 42));
    sb.push_back(mk("frac 10/3", 853, 1, 0, 0, 42));
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 32'd1, 32'd2);
        1:       drive(1'b1, -32'sd3, 32'd4);
        default: drive(1'b1, 32'd10, 32'd3);
      endcase
      collect(1'b1);
      e = sb.pop_front();
      checks++;
      if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
        fails++;
        $display("[TB] FAIL %s: got lat=%0d q=%0d r=%0d err=%b ovf=%b, expected lat=%0d q=%0d r=%0d err=%b ovf=%b",
                 e.name, obsLat, $signed(obsQ), $signed(obsR), obsErr, obsOvf, e.lat, $signed(e.q), $signed(e.r), e.err, e.ovf);
      end
      accept(1'b1);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    bit   seen;
    sb.push_back(mk("hold 100/7", 14, 2, 0, 0, 34));
    drive(1'b0, 32'd100, 32'd7);
    collect(1'b0);
    e = sb.pop_front();
    checks++;
    if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
      fails++;
      $display("[TB] FAIL %s: got lat=%0d q=%0d err=%b ovf=%b, expected lat=%0d q=%0d err=%b ovf=%b",
               e.name, obsLat, $signed(obsQ), obsErr, obsOvf, e.lat, $signed(e.q), e.err, e.ovf);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vout0 !== 1'b1 || quot0 !== 20'd14 || rdy0 !== 1'b0 || busy0 !== 1'b1) begin
        fails++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b q=%0d ready=%b busy=%b expected 1/14/0/1", i, vout0, $signed(quot0), rdy0, busy0);
      end
      if (i == 1) begin dvd0 = 32'd50; dsr0 = 32'd5; vin0 = 1'b1; end
      if (i == 3) vin0 = 1'b0;
      @(negedge clk);
    end
    rin0 = 1'b1;
    @(posedge clk);
    #1;
    rin0 = 1'b0;
    checks++;
    if (vout0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hold_release: got valid=%b ready=%b busy=%b expected 0/1/0", vout0, rdy0, busy0);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vout0 || busy0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hold_ignored: got activity=%b expected 0 after ignored valid_in", seen);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    drive(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || vout0 !== 1'b0 || rdy0 !== 1'b0 || quot0 !== '0 || err0 !== 1'b0 || ovf0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got busy=%b valid=%b ready=%b q=%0d err=%b ovf=%b expected all 0",
               busy0, vout0, rdy0, quot0, err0, ovf0);
    end
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (vout0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_novalid: got valid pulse=%b expected 0", seen);
    end
    sb.push_back(mk("post-reset 9/3", 3, 0, 0, 0, 34));
    drive(1'b0, 32'd9, 32'd3);
    collect(1'b0);
    e = sb.pop_front();
    checks++;
    if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
      fails++;
      $display("[TB] FAIL %s: got lat=%0d q=%0d err=%b ovf=%b, expected lat=%0d q=%0d err=%b ovf=%b",
               e.name, obsLat, $signed(obsQ), obsErr, obsOvf, e.lat, $signed(e.q), e.err, e.ovf);
    end
    accept(1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    logic [W-1:0] a, b;
    bit           which;
    rin0 = 1'b1;
    rin8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      which = (i % 4 == 3);
      if (which) begin
        a = $urandom_range(0, 200000);
        b = $urandom_range(1, 1000);
      end else begin
        a = $urandom;
        b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      end
      if ($urandom_range(0, 1) == 1) a = ~a + 1'b1;
      if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
      sb.push_back(model($sformatf("b2b%0d", i), a, b, which ? 8 : 0));
      drive(which, a, b);
      collect(which);
      e = sb.pop_front();
      checks++;
      if (obsLat !== e.lat || obsQ !== e.q || obsErr !== e.err || obsOvf !== e.ovf || (REM_EN && obsR !== e.r)) begin
        fails++;
        $display("[TB] FAIL %s (%0d/%0d): got lat=%0d q=%0d r=%0d err=%b ovf=%b, expected lat=%0d q=%0d r=%0d err=%b ovf=%b",
                 e.name, $signed(a), $signed(b), obsLat, $signed(obsQ), $signed(obsR), obsErr, obsOvf,
                 e.lat, $signed(e.q), $signed(e.r), e.err, e.ovf);
      end
    end
    @(posedge clk);
    #1;
    rin0 = 1'b0;
    rin8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_frac();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
